// File: rtl/hs_pipeline_pkg.sv
// Shared constants and types for the handshake pipeline buffer.
// Handshake mode encodings, output FSM states and a constant clog2.
package hs_pipeline_pkg;

    localparam int MODE_4PH = 4;
    localparam int MODE_2PH = 2;

    typedef enum logic {
        OUT_IDLE,
        OUT_BUSY
    } out_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/hs_fifo_core.sv
// Circular word store with wrap-around pointers, occupancy and a
// registered head-first view of every entry.
module hs_fifo_core
    import hs_pipeline_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             head,
    output logic [DEPTH-1:0]             stage_req,
    output logic [DEPTH*WIDTH-1:0]       stage_data,
    output logic [clog2(DEPTH+1)-1:0]    count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0]       mem   [DEPTH];
    logic [WIDTH-1:0]       mem_n [DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr, wr_n, rd_n;
    logic [CW-1:0]          count_n;
    logic [DEPTH-1:0]       req_n;
    logic [DEPTH*WIDTH-1:0] data_n;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] idx(input logic [PW-1:0] base,
                                          input int off);
        logic [PW:0] s;
        s = {1'b0, base} + (PW+1)'(off);
        if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
        return s[PW-1:0];
    endfunction

    assign head = mem[rd_ptr];

    // Stage view is built from next state so it registers alongside count.
    always_comb begin
        mem_n = mem;
        if (push) mem_n[wr_ptr] = din;
        wr_n = push ? inc(wr_ptr) : wr_ptr;
        rd_n = pop ? inc(rd_ptr) : rd_ptr;
        count_n = count;
        if (push && !pop)
            count_n = count + CW'(1);
        else if (pop && !push)
            count_n = count - CW'(1);
        req_n  = '0;
        data_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_n) begin
                req_n[i] = 1'b1;
                data_n[i*WIDTH +: WIDTH] = mem_n[idx(rd_n, i)];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            stage_req  <= '0;
            stage_data <= '0;
        end else begin
            mem        <= mem_n;
            wr_ptr     <= wr_n;
            rd_ptr     <= rd_n;
            count      <= count_n;
            full       <= (count_n == CW'(DEPTH));
            empty      <= (count_n == '0);
            stage_req  <= req_n;
            stage_data <= data_n;
        end
    end

endmodule

// File: rtl/hs_pipeline.sv
// Handshake pipeline buffer: producer/consumer handshake FSMs in
// four-phase or two-phase mode around a circular FIFO core.
module hs_pipeline
    import hs_pipeline_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int MODE  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         request_in,
    output logic                         ack_out,
    output logic [WIDTH-1:0]             data_out,
    output logic                         request_out,
    input  logic                         ack_in,
    output logic [DEPTH-1:0]             stage_req,
    output logic [DEPTH*WIDTH-1:0]       stage_data,
    output logic [clog2(DEPTH+1)-1:0]    count,
    output logic                         full,
    output logic                         empty
);

    localparam bit FOUR_PH = (MODE == MODE_4PH);

    logic             push, pop, present;
    logic [WIDTH-1:0] head;
    out_state_t       out_state;

    hs_fifo_core #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       (data_in),
        .head      (head),
        .stage_req (stage_req),
        .stage_data(stage_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Full and empty are registered, so no same-edge pass-through occurs.
    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        present = 1'b0;
        if (FOUR_PH) begin
            push    = request_in && !ack_out && !full;
            pop     = (out_state == OUT_BUSY) && ack_in;
            present = (out_state == OUT_IDLE) && !empty && !ack_in;
        end else begin
            push    = (request_in != ack_out) && !full;
            pop     = (out_state == OUT_BUSY) && (ack_in == request_out);
            present = (out_state == OUT_IDLE) && !empty
                      && (ack_in == request_out);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_out     <= 1'b0;
            request_out <= 1'b0;
            data_out    <= '0;
            out_state   <= OUT_IDLE;
        end else begin
            if (FOUR_PH) begin
                if (push)
                    ack_out <= 1'b1;
                else if (!request_in)
                    ack_out <= 1'b0;
            end else if (push) begin
                ack_out <= !ack_out;
            end

            if (pop) begin
                out_state <= OUT_IDLE;
                if (FOUR_PH) request_out <= 1'b0;
            end else if (present) begin
                out_state   <= OUT_BUSY;
                data_out    <= head;
                request_out <= FOUR_PH ? 1'b1 : !request_out;
            end
        end
    end

endmodule

// File: tb/tb_hs_pipeline.sv
// Scoreboard bench for hs_pipeline: a four-phase instance (WIDTH 4)
// and a two-phase instance (WIDTH 8) sharing clock and reset.
module tb_hs_pipeline;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [3:0]  a_din;
    logic        a_req = 1'b0;
    logic        a_ack_out;
    logic [3:0]  a_dout;
    logic        a_rout;
    logic        a_ack = 1'b0;
    logic [3:0]  a_sreq;
    logic [15:0] a_sdata;
    logic [2:0]  a_cnt;
    logic        a_full, a_empty;

    logic [7:0]  b_din;
    logic        b_req = 1'b0;
    logic        b_ack_out;
    logic [7:0]  b_dout;
    logic        b_rout;
    logic        b_ack = 1'b0;
    logic [3:0]  b_sreq;
    logic [31:0] b_sdata;
    logic [2:0]  b_cnt;
    logic        b_full, b_empty;

    hs_pipeline #(.WIDTH(4), .DEPTH(4), .MODE(4)) u4 (
        .clk(clk), .reset(reset),
        .data_in(a_din), .request_in(a_req), .ack_out(a_ack_out),
        .data_out(a_dout), .request_out(a_rout), .ack_in(a_ack),
        .stage_req(a_sreq), .stage_data(a_sdata), .count(a_cnt),
        .full(a_full), .empty(a_empty)
    );

    hs_pipeline #(.WIDTH(8), .DEPTH(4), .MODE(2)) u2 (
        .clk(clk), .reset(reset),
        .data_in(b_din), .request_in(b_req), .ack_out(b_ack_out),
        .data_out(b_dout), .request_out(b_rout), .ack_in(b_ack),
        .stage_req(b_sreq), .stage_data(b_sdata), .count(b_cnt),
        .full(b_full), .empty(b_empty)
    );

    int nchk = 0;
    int nerr = 0;
    int b_n  = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit a_en = 0, a_rand = 0, b_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Four-phase consumer: optional random ack delay.
    initial forever begin
        @(negedge clk);
        if (!reset || !a_rout)
            a_ack = 1'b0;
        else if (!a_ack && a_en && (!a_rand || $urandom_range(0, 2) == 0))
            a_ack = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (b_en && (b_rout != b_ack)) b_ack = b_rout;
    end

    logic a_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (a_rout && !a_prev) begin
            if (qa.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL a_unexpected: got %0h expected none", a_dout);
            end else begin
                chk("a_order", 32'(a_dout), 32'(qa.pop_front()));
            end
        end
        a_prev = a_rout;
    end

    logic b_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (b_rout != b_prev) begin
            b_n++;
            if (qb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL b_unexpected: got %0h expected none", b_dout);
            end else begin
                chk("b_order", 32'(b_dout), 32'(qb.pop_front()));
            end
        end
        b_prev = b_rout;
    end

    task automatic send_a(input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        a_din = d;
        a_req = 1'b1;
        qa.push_back(8'(d));
        do begin @(posedge clk); #1; n++; end
        while (!a_ack_out && n < 64);
        chk("a_ack_rise", 32'(a_ack_out), 32'd1);
        @(negedge clk);
        a_req = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end
        while (a_ack_out && n < 64);
        chk("a_ack_fall", 32'(a_ack_out), 32'd0);
    endtask

    task automatic send_b(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        b_din = d;
        b_req = ~b_req;
        qb.push_back(d);
        do begin @(posedge clk); #1; n++; end
        while (b_ack_out != b_req && n < 64);
        chk("b_ack_toggle", 32'(b_ack_out), 32'(b_req));
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while ((qa.size() != 0 || a_rout || !a_empty) && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        chk("a_drain_empty", 32'(a_empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_din = '0;
        b_din = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_a_flags", {a_ack_out, a_rout, a_full, a_empty}, 32'b0001);
        chk("rst_a_cnt", {a_cnt, a_sreq, a_dout}, 32'd0);
        chk("rst_a_sdata", 32'(a_sdata), 32'd0);
        chk("rst_b_flags", {b_ack_out, b_rout, b_full, b_empty}, 32'b0001);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // single word, four-phase
        @(negedge clk);
        a_din = 4'd1;
        a_req = 1'b1;
        qa.push_back(8'd1);
        @(posedge clk); #1;
        chk("w1_ack", {a_ack_out, a_rout}, 32'b10);
        chk("w1_stage", {a_cnt, a_sreq, a_sdata}, {3'd1, 4'b0001, 16'h0001});
        @(negedge clk) a_req = 1'b0;
        @(posedge clk); #1;
        chk("w1_req", {a_rout, a_dout, a_ack_out}, {1'b1, 4'd1, 1'b0});
        a_en = 1;
        a_rand = 0;
        @(posedge clk); #1;
        chk("w1_pop", {a_rout, a_empty}, 32'b01);
        a_en = 0;

        // fill to full, fifth word held off
        for (int i = 1; i <= 4; i++) send_a(4'(i));
        @(negedge clk);
        a_din = 4'd5;
        a_req = 1'b1;
        qa.push_back(8'd5);
        repeat (3) @(posedge clk);
        #1;
        chk("full_hold", {a_ack_out, a_full, a_cnt}, {1'b0, 1'b1, 3'd4});
        chk("full_stage", {a_sreq, a_sdata}, {4'b1111, 16'h4321});
        a_en = 1;
        @(posedge clk); #1;
        chk("full_pop", {a_full, a_ack_out, a_cnt, a_rout},
            {1'b0, 1'b0, 3'd3, 1'b0});
        a_en = 0;
        @(posedge clk); #1;
        chk("full_accept", {a_ack_out, a_cnt, a_full}, {1'b1, 3'd4, 1'b1});
        @(negedge clk) a_req = 1'b0;

        // streaming with random consumer delay, pointers wrap
        a_en = 1;
        a_rand = 1;
        for (int i = 1; i <= 10; i++) send_a(4'(i));
        drain_a();

        // simultaneous push and pop at count 2
        a_en = 0;
        a_rand = 0;
        send_a(4'hA);
        send_a(4'hB);
        @(posedge clk); #1;
        chk("pp_pre", {a_cnt, a_rout, a_dout}, {3'd2, 1'b1, 4'hA});
        a_en = 1;
        @(negedge clk);
        a_din = 4'hC;
        a_req = 1'b1;
        qa.push_back(8'hC);
        @(posedge clk); #1;
        chk("pp_cnt", {a_cnt, a_ack_out, a_rout}, {3'd2, 1'b1, 1'b0});
        chk("pp_stage", {a_sreq, a_sdata}, {4'b0011, 16'h00CB});
        @(negedge clk) a_req = 1'b0;
        drain_a();

        // reset mid-transfer
        a_en = 0;
        send_a(4'd1);
        send_a(4'd2);
        send_a(4'd3);
        @(posedge clk); #1;
        chk("mr_pre", {a_cnt, a_rout}, {3'd3, 1'b1});
        #2 reset = 1'b0;
        #1;
        chk("mr_flags", {a_ack_out, a_rout, a_full, a_empty}, 32'b0001);
        chk("mr_zero", {a_cnt, a_sreq, a_dout, a_sdata}, 32'd0);
        qa.delete();
        @(negedge clk) reset = 1'b1;
        a_en = 1;
        send_a(4'd9);
        drain_a();

        // two-phase instance
        b_en = 1;
        send_b(8'hA5);
        send_b(8'h5A);
        send_b(8'hFF);
        for (int n = 0; n < 200; n++) begin
            if (qb.size() == 0 && b_rout == b_ack && b_empty) break;
            @(posedge clk); #1;
        end
        chk("b_deliveries", 32'(b_n), 32'd3);
        chk("b_final", {b_rout, b_ack_out, b_empty, b_cnt},
            {1'b1, 1'b1, 1'b1, 3'd0});
        chk("queues_empty", 32'(qa.size() + qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/hs_pipeline.md
HS_PIPELINE -- requirements
Module: hs_pipeline

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of buffer stages (>=2).
REQ-003 SHALL have parameter MODE, default 4, handshake protocol: 4 = four-phase return-to-zero, 2 = two-phase transition; other values are illegal.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port data_in  input  WIDTH  producer word.
REQ-007 SHALL have port request_in  input  1  producer request, synchronous to clk.
REQ-008 SHALL have port ack_out  output  1  acknowledge to producer.
REQ-009 SHALL have port data_out  output  WIDTH  head word to consumer.
REQ-010 SHALL have port request_out  output  1  request to consumer.
REQ-011 SHALL have port ack_in  input  1  consumer acknowledge, synchronous to clk.
REQ-012 SHALL have port stage_req  output  DEPTH  bit i set when entry i (0 = head) holds valid data.
REQ-013 SHALL have port stage_data  output  DEPTH*WIDTH  entry i at bits [i*WIDTH +: WIDTH]; invalid entries read 0.
REQ-014 SHALL have port count  output  clog2(DEPTH+1)  number of valid entries.
REQ-015 SHALL have ports full, empty  output  1 each  count==DEPTH, count==0.

Function
REQ-016 Input, MODE 4: at an edge with request_in=1, ack_out=0, full=0, SHALL write data_in at tail and set ack_out=1; ack_out SHALL clear at the first edge with request_in=0.
REQ-017 Input, MODE 2: at an edge with request_in != ack_out and full=0, SHALL write data_in and toggle ack_out.
REQ-018 While full=1, SHALL not accept; request stays pending and is accepted at the first edge where full=0 is registered (no same-edge full pass-through).
REQ-019 Output, MODE 4: at an edge with empty=0, request_out=0, ack_in=0, SHALL drive head on data_out and set request_out=1; at an edge with request_out=1, ack_in=1, SHALL pop head and clear request_out.
REQ-020 Output, MODE 2: when empty=0 and request_out==ack_in, SHALL present head and toggle request_out; pop SHALL occur at the edge where ack_in first equals request_out again.
REQ-021 data_out SHALL stay stable while a request is outstanding.
REQ-022 Latency: word written at edge k into an empty buffer SHALL raise/toggle request_out after edge k+1.
REQ-023 Simultaneous push and pop at one edge SHALL leave count unchanged and preserve order.
REQ-024 Storage SHALL be circular with wrap-around pointers; order is strictly FIFO.
REQ-025 count, full, empty, stage_req, stage_data SHALL be registered and consistent at every edge.

Reset
REQ-026 reset=0 SHALL immediately force ack_out=0, request_out=0, data_out=0, count=0, empty=1, full=0, stage_req=0, stage_data=0, pointers 0.
REQ-027 Reset mid-transfer SHALL discard all contents; after release the block is idle and, in MODE 2, treats request_in/ack_in level 0 as the reference phase.

Structure
REQ-028 Package hs_pipeline_pkg SHALL hold MODE_4PH=4, MODE_2PH=2 and a clog2 function.
REQ-029 SHALL instantiate one sub-module hs_fifo_core (storage, pointers, count, stage view); handshake FSMs stay in hs_pipeline.

Verification
REQ-030 Single word, MODE 4, DEPTH 4: request_in=1 data_in=1 -> ack_out=1 next edge, request_out=1 with data_out=1 one edge later; ack_in=1 -> request_out=0, empty=1.
REQ-031 Fill: five words 1..5, ack_in held 0 -> words 1..4 accepted, full=1, count=4, stage_req=4'b1111, word 5 ack withheld until one pop, then accepted.
REQ-032 Order/wrap: 10 words 1..10 streamed with random consumer delays -> data_out sequence 1..10 exactly.
REQ-033 MODE 2, WIDTH 8: three request_in toggles with data 8'hA5, 8'h5A, 8'hFF -> three ack_out toggles, request_out toggles delivering same order.
REQ-034 Simultaneous push/pop at count=2 -> count stays 2, order preserved.
REQ-035 Reset asserted with count=3 and request_out=1 -> all outputs 0, empty=1 immediately; next word after release delivered normally.
